fa_bist_checker: RTL and testbench

FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

---
 rtl/fa_pkg.sv | 15 +
 rtl/fa_golden.sv | 13 +
 rtl/fa_bist_checker.sv | 107 ++++++++++
 tb/tb_fa_bist_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared constants and FSM state encoding for the full-adder BIST checker.
package fa_pkg;

    localparam int unsigned VEC_W   = 3;
    localparam int unsigned NUM_VEC = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/fa_golden.sv
// Combinational full-adder reference used to generate expected responses.
module fa_golden (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ c;
    assign co = (a & b) | (b & c) | (a & c);

endmodule

// File: rtl/fa_bist_checker.sv
// Exhaustive BIST sequencer for a 1-bit full adder: applies 000..111, compares
// against fa_golden, and reports the mismatch count and the first failing vector.
module fa_bist_checker
    import fa_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       tv_a,
    output logic       tv_b,
    output logic       tv_c,
    input  logic       dut_s,
    input  logic       dut_co,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_vec,
    output logic       fail_valid
);

    localparam logic [3:0]       SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VEC - 1);

    state_t           state;
    logic [VEC_W-1:0] idx;
    logic [3:0]       settle_cnt;
    logic             gold_s;
    logic             gold_co;
    logic             mismatch;

    fa_golden u_golden (
        .a  (idx[2]),
        .b  (idx[1]),
        .c  (idx[0]),
        .s  (gold_s),
        .co (gold_co)
    );

    assign {tv_a, tv_b, tv_c} = idx;
    assign mismatch = (dut_s != gold_s) || (dut_co != gold_co);

    // busy/done/pass lag the state by one cycle; in DONE, busy still high marks
    // the first DONE cycle, which is where the done pulse and pass are produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            fail_vec   <= '0;
            fail_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (state == ST_DONE && busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (err_cnt == 4'd0);
                    end else if (start) begin
                        state      <= ST_APPLY;
                        idx        <= '0;
                        err_cnt    <= '0;
                        fail_vec   <= '0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    busy       <= 1'b1;
                    settle_cnt <= '0;
                    state      <= (SETTLE != 0) ? ST_SETTLE : ST_CHECK;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 4'd1;
                        if (!fail_valid) begin
                            fail_vec   <= idx;
                            fail_valid <= 1'b1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + VEC_W'(1);
                        state <= ST_APPLY;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fa_bist_checker.sv
// Directed bench: two checker instances (SETTLE=1 and SETTLE=0) each driving a
// behavioural full adder with selectable faults.
module tb_fa_bist_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n1 = 1'b1, rst_n0 = 1'b1;
    logic start1 = 1'b0, start0 = 1'b0;
    int   fault1 = 0, fault0 = 0;

    logic       a1, b1, c1, s1, co1, busy1, done1, pass1, fvv1;
    logic [3:0] err1;
    logic [2:0] fv1;
    logic       a0, b0, c0, s0, co0, busy0, done0, pass0, fvv0;
    logic [3:0] err0;
    logic [2:0] fv0;

    // fault 1: carry stuck at 0, fault 2: sum inverted
    assign s1  = (a1 ^ b1 ^ c1) ^ (fault1 == 2);
    assign co1 = ((a1 & b1) | (b1 & c1) | (a1 & c1)) & (fault1 != 1);
    assign s0  = (a0 ^ b0 ^ c0) ^ (fault0 == 2);
    assign co0 = ((a0 & b0) | (b0 & c0) | (a0 & c0)) & (fault0 != 1);

    fa_bist_checker #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n1), .start(start1),
        .tv_a(a1), .tv_b(b1), .tv_c(c1), .dut_s(s1), .dut_co(co1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .fail_vec(fv1), .fail_valid(fvv1)
    );

    fa_bist_checker #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst_n(rst_n0), .start(start0),
        .tv_a(a0), .tv_b(b0), .tv_c(c0), .dut_s(s0), .dut_co(co0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .fail_vec(fv0), .fail_valid(fvv0)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int cyc;
    logic [2:0] tr_tv[64];
    logic       tr_busy[64];
    logic [3:0] tr_err[64];

    // Starts a run (start high over edge k) and records a per-cycle trace
    // sampled 1 ns after edges k+n until done is seen; cyc = -1 on timeout.
    task automatic run_and_wait(input bit use_s1, input int repulse_at, output int c);
        @(negedge clk);
        if (use_s1) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        #1;
        if (use_s1) start1 = 1'b0; else start0 = 1'b0;
        c = -1;
        for (int n = 0; n < 64; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            tr_tv[n]   = use_s1 ? {a1, b1, c1} : {a0, b0, c0};
            tr_busy[n] = use_s1 ? busy1 : busy0;
            tr_err[n]  = use_s1 ? err1 : err0;
            if (use_s1) start1 = (n == repulse_at); else start0 = (n == repulse_at);
            if (use_s1 ? done1 : done0) begin
                c = n;
                break;
            end
        end
        start1 = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst_n1 = 1'b0;
        rst_n0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fv1, fvv1} !== '0) begin
            n_miss++;
            $display("FAIL reset_s1: got %h exp 0", {a1, b1, c1, busy1, done1, pass1, err1, fv1, fvv1});
        end
        n_vec++;
        if ({a0, b0, c0, busy0, done0, pass0, err0, fv0, fvv0} !== '0) begin
            n_miss++;
            $display("FAIL reset_s0: got %h exp 0", {a0, b0, c0, busy0, done0, pass0, err0, fv0, fvv0});
        end
        @(negedge clk);
        rst_n1 = 1'b1;
        rst_n0 = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_good_run();
        fault1 = 0;
        run_and_wait(1'b1, -1, cyc);
        n_vec++;
        if (cyc !== 25) begin n_miss++; $display("FAIL good_done_cycle: got %0d exp 25", cyc); end
        n_vec++;
        if (tr_busy[0] !== 1'b0) begin n_miss++; $display("FAIL good_busy_k: got %b exp 0", tr_busy[0]); end
        n_vec++;
        if (tr_busy[1] !== 1'b1) begin n_miss++; $display("FAIL good_busy_k1: got %b exp 1", tr_busy[1]); end
        for (int n = 0; n < 24; n++) begin
            n_vec++;
            if (tr_tv[n] !== 3'(n / 3)) begin
                n_miss++;
                $display("FAIL good_vec_order[%0d]: got %0d exp %0d", n, tr_tv[n], n / 3);
            end
        end
        n_vec++;
        if ({pass1, err1, fvv1} !== {1'b1, 4'd0, 1'b0}) begin
            n_miss++;
            $display("FAIL good_result: got pass=%b err=%0d fv=%b exp pass=1 err=0 fv=0", pass1, err1, fvv1);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({done1, busy1, pass1} !== 3'b001) begin
            n_miss++;
            $display("FAIL good_after_done: got done=%b busy=%b pass=%b exp 0 0 1", done1, busy1, pass1);
        end
    endtask

    task automatic test_co_stuck();
        fault1 = 1;
        run_and_wait(1'b1, -1, cyc);
        n_vec++;
        if (cyc !== 25) begin n_miss++; $display("FAIL co_done_cycle: got %0d exp 25", cyc); end
        n_vec++;
        if (err1 !== 4'd4) begin n_miss++; $display("FAIL co_err_cnt: got %0d exp 4", err1); end
        n_vec++;
        if ({fvv1, fv1} !== 4'b1011) begin
            n_miss++;
            $display("FAIL co_fail_vec: got valid=%b vec=%b exp 1 011", fvv1, fv1);
        end
        n_vec++;
        if (pass1 !== 1'b0) begin n_miss++; $display("FAIL co_pass: got %b exp 0", pass1); end
        @(posedge clk);
    endtask

    task automatic test_s_inverted();
        fault1 = 2;
        run_and_wait(1'b1, -1, cyc);
        n_vec++;
        if (err1 !== 4'd8) begin n_miss++; $display("FAIL sinv_err_cnt: got %0d exp 8", err1); end
        n_vec++;
        if ({fvv1, fv1} !== 4'b1000) begin
            n_miss++;
            $display("FAIL sinv_fail_vec: got valid=%b vec=%b exp 1 000", fvv1, fv1);
        end
        n_vec++;
        if (pass1 !== 1'b0) begin n_miss++; $display("FAIL sinv_pass: got %b exp 0", pass1); end
        @(posedge clk);
    endtask

    task automatic test_start_ignored();
        fault1 = 0;
        run_and_wait(1'b1, 7, cyc);
        n_vec++;
        if (cyc !== 25) begin n_miss++; $display("FAIL busy_start_done_cycle: got %0d exp 25", cyc); end
        for (int n = 0; n < 24; n++) begin
            n_vec++;
            if (tr_tv[n] !== 3'(n / 3)) begin
                n_miss++;
                $display("FAIL busy_start_vec_order[%0d]: got %0d exp %0d", n, tr_tv[n], n / 3);
            end
        end
        n_vec++;
        if (pass1 !== 1'b1) begin n_miss++; $display("FAIL busy_start_pass: got %b exp 1", pass1); end
        @(posedge clk);
    endtask

    task automatic test_reset_midrun();
        fault1 = 1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_vec++;
        if ({busy1, a1, b1, c1} !== 4'b1011) begin
            n_miss++;
            $display("FAIL midrun_pre: got busy=%b tv=%b exp 1 011", busy1, {a1, b1, c1});
        end
        #2;
        rst_n1 = 1'b0;
        #1;
        n_vec++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fv1, fvv1} !== '0) begin
            n_miss++;
            $display("FAIL midrun_async_reset: got %h exp 0", {a1, b1, c1, busy1, done1, pass1, err1, fv1, fvv1});
        end
        @(negedge clk);
        rst_n1 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_vec++;
        if ({a1, b1, c1, busy1, done1, pass1, err1, fv1, fvv1} !== '0) begin
            n_miss++;
            $display("FAIL midrun_no_resume: got %h exp 0", {a1, b1, c1, busy1, done1, pass1, err1, fv1, fvv1});
        end
        fault1 = 0;
    endtask

    task automatic test_restart_from_done();
        fault0 = 2;
        run_and_wait(1'b0, -1, cyc);
        n_vec++;
        if (cyc !== 17) begin n_miss++; $display("FAIL s0_fail_done_cycle: got %0d exp 17", cyc); end
        n_vec++;
        if ({pass0, err0} !== {1'b0, 4'd8}) begin
            n_miss++;
            $display("FAIL s0_fail_result: got pass=%b err=%0d exp 0 8", pass0, err0);
        end
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy0, done0, err0, fvv0} !== {1'b0, 1'b0, 4'd8, 1'b1}) begin
            n_miss++;
            $display("FAIL s0_hold_in_done: got busy=%b done=%b err=%0d fv=%b exp 0 0 8 1", busy0, done0, err0, fvv0);
        end
        fault0 = 0;
        run_and_wait(1'b0, -1, cyc);
        n_vec++;
        if (tr_err[0] !== 4'd0) begin n_miss++; $display("FAIL s0_err_cleared: got %0d exp 0", tr_err[0]); end
        n_vec++;
        if (cyc !== 17) begin n_miss++; $display("FAIL s0_good_done_cycle: got %0d exp 17", cyc); end
        for (int n = 0; n < 16; n++) begin
            n_vec++;
            if (tr_tv[n] !== 3'(n / 2)) begin
                n_miss++;
                $display("FAIL s0_vec_order[%0d]: got %0d exp %0d", n, tr_tv[n], n / 2);
            end
        end
        n_vec++;
        if ({pass0, err0, fvv0} !== {1'b1, 4'd0, 1'b0}) begin
            n_miss++;
            $display("FAIL s0_good_result: got pass=%b err=%0d fv=%b exp 1 0 0", pass0, err0, fvv0);
        end
    endtask

    initial begin
        test_reset();
        test_good_run();
        test_co_stuck();
        test_s_inverted();
        test_start_ignored();
        test_reset_midrun();
        test_restart_from_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
